cacc_dbuf_ram_ctrl: RTL and testbench

// Initiator side of the CACC 32x512 two-port data-buffer RAM.
// - Turns a valid/ready write stream into RAM write-port cycles, and RAM read-port cycles into a valid/ready read stream.
// - Owns pointers and occupancy, absorbs the RAM's 1-cycle read latency with a 2-entry output skid, and sustains 1 word/cycle each way.
// - Sits between the CACC assembly datapath and the external RAM macro.

---
 rtl/cacc_dbuf_pkg.sv | 12 +
 rtl/cacc_dbuf_ram_ctrl_if.sv | 29 ++
 rtl/cacc_dbuf_skid.sv | 54 +++++
 rtl/cacc_dbuf_ram_ctrl.sv | 101 ++++++++++
 tb/tb_cacc_dbuf_ram_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cacc_dbuf_pkg.sv
// Shared sizing and types for the CACC data-buffer RAM controller.
// Latency: none (constants and types only).
// Backpressure: none (constants and types only).
package cacc_dbuf_pkg;
    localparam int DW    = 512;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int CW    = 6;

    typedef logic [DW-1:0] data_t;
    typedef logic [CW-1:0] occ_t;
endpackage

// File: rtl/cacc_dbuf_ram_ctrl_if.sv
// Write stream, read stream and RAM port bundle for the data-buffer controller.
// Latency: none (wires only).
// Backpressure: carried by in_ready and out_ready.
interface cacc_dbuf_ram_ctrl_if;
    import cacc_dbuf_pkg::*;

    logic          in_valid;
    logic          in_ready;
    data_t         in_pd;
    logic          out_valid;
    logic          out_ready;
    data_t         out_pd;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    data_t         ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    data_t         ram_dout;

    modport master (
        input  in_valid, in_pd, out_ready, ram_dout,
        output in_ready, out_valid, out_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra
    );

    modport slave (
        output in_valid, in_pd, out_ready, ram_dout,
        input  in_ready, out_valid, out_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra
    );
endinterface

// File: rtl/cacc_dbuf_skid.sv
// 2-entry output FIFO that absorbs the RAM read latency.
// Latency: a push is visible at head_pd the cycle after the push edge.
// Backpressure: caller never pushes when full or pops when empty.
module cacc_dbuf_skid
    import cacc_dbuf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  data_t      push_pd,
    input  logic       pop,
    output logic [1:0] cnt,
    output data_t      head_pd
);
    data_t      mem_q [2];
    data_t      mem_d [2];
    logic       wr_idx_q, wr_idx_d;
    logic       rd_idx_q, rd_idx_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (push) begin
            mem_d[wr_idx_q] = push_pd;
            wr_idx_d        = ~wr_idx_q;
        end
        if (pop) begin
            rd_idx_d = ~rd_idx_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data entries need no reset; cnt_q alone qualifies them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cnt     = cnt_q;
    assign head_pd = mem_q[rd_idx_q];
endmodule

// File: rtl/cacc_dbuf_ram_ctrl.sv
// Write/read stream controller for the CACC 32x512 two-port RAM; optional stats under CACC_DBUF_STATS_EN.
// Latency: word accepted at edge k is on out_pd after edge k+2; 1 word/cycle sustained.
// Backpressure: in_ready drops when the RAM is full; reads stall while the 2-entry skid is committed.
module cacc_dbuf_ram_ctrl
    import cacc_dbuf_pkg::*;
(
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    cacc_dbuf_ram_ctrl_if.master bus,
    output occ_t                 occupancy
`ifdef CACC_DBUF_STATS_EN
    ,
    output occ_t                 hwm,
    output logic [1:0]           ovf_seen
`endif
);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    occ_t          ram_cnt_q, ram_cnt_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic [1:0]    skid_cnt;
    data_t         skid_head;
    logic          wr_en;
    logic          rd_en;
    logic          pop;
    logic [2:0]    rd_pend;

    cacc_dbuf_skid u_skid (
        .clk     (nvdla_core_clk),
        .rst     (nvdla_core_rst),
        .push    (rd_inflight_q),
        .push_pd (bus.ram_dout),
        .pop     (pop),
        .cnt     (skid_cnt),
        .head_pd (skid_head)
    );

    assign bus.out_valid = (skid_cnt != 2'd0);
    assign bus.out_pd    = skid_head;
    assign pop           = bus.out_valid & bus.out_ready;

    // in_ready looks only at registered state, so it never waits on the same-cycle read.
    assign bus.in_ready  = (ram_cnt_q < occ_t'(DEPTH));
    assign wr_en         = bus.in_valid & bus.in_ready;

    // Issue only if the word still has a skid slot after this cycle's pop.
    assign rd_pend = {1'b0, skid_cnt} + {2'b00, rd_inflight_q} - {2'b00, pop};
    assign rd_en   = (ram_cnt_q != '0) && (rd_pend < 3'd2);

    assign bus.ram_we = wr_en;
    assign bus.ram_wa = wr_ptr_q;
    assign bus.ram_di = bus.in_pd;
    assign bus.ram_re = rd_en;
    assign bus.ram_ra = rd_ptr_q;

    assign occupancy = ram_cnt_q + occ_t'(rd_inflight_q) + occ_t'(skid_cnt);

    always_comb begin
        wr_ptr_d      = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ram_cnt_d     = ram_cnt_q + occ_t'(wr_en) - occ_t'(rd_en);
        rd_inflight_d = rd_en;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

`ifdef CACC_DBUF_STATS_EN
    occ_t hwm_q, hwm_d;
    logic ovf_q, ovf_d;

    always_comb begin
        hwm_d = (occupancy > hwm_q) ? occupancy : hwm_q;
        ovf_d = ovf_q | (bus.in_valid & ~bus.in_ready);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            hwm_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            hwm_q <= hwm_d;
            ovf_q <= ovf_d;
        end
    end

    assign hwm      = hwm_q;
    assign ovf_seen = {1'b0, ovf_q};
`endif
endmodule

// File: tb/tb_cacc_dbuf_ram_ctrl.sv
// Bench for cacc_dbuf_ram_ctrl: RAM model, queue scoreboard, directed and random traffic.
// Latency: checks the 2-edge fill and 1 word/cycle streaming.
// Backpressure: drives full, stalled and toggling out_ready cases.
module tb_cacc_dbuf_ram_ctrl;
    import cacc_dbuf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    occ_t occupancy;
`ifdef CACC_DBUF_STATS_EN
    occ_t       hwm;
    logic [1:0] ovf_seen;
`endif

    cacc_dbuf_ram_ctrl_if bus ();

    cacc_dbuf_ram_ctrl dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .bus            (bus),
        .occupancy      (occupancy)
`ifdef CACC_DBUF_STATS_EN
        ,
        .hwm            (hwm),
        .ovf_seen       (ovf_seen)
`endif
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    pops_n = 0;
    data_t exp_q [$];
    data_t ram [DEPTH];
    logic  stall_vld = 1'b0;
    data_t stall_pd;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic data_t rand_word();
        data_t w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAM macro: 1-cycle read, garbage on dout when not reading.
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_wa] <= bus.ram_di;
        if (bus.ram_re) bus.ram_dout <= ram[bus.ram_ra];
        else            bus.ram_dout <= rand_word();
    end

    // Scoreboard: every held word is in exp_q, and the DUT must pop them in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_vld = 1'b0;
        end else begin
            chk("occupancy", DW'(occupancy), DW'(exp_q.size()));
            if (bus.ram_we && bus.ram_re) chk("ram_collision", DW'(bus.ram_wa == bus.ram_ra), '0);
            if (stall_vld) begin
                chk("stall_vld", DW'(bus.out_valid), DW'(1));
                chk("stall_pd", bus.out_pd, stall_pd);
            end
            if (bus.out_valid && bus.out_ready) begin
                pops_n++;
                if (exp_q.size() == 0) chk("pop_from_empty", DW'(1), '0);
                else                   chk("pop_pd", bus.out_pd, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_pd);
            stall_vld = bus.out_valid && !bus.out_ready;
            stall_pd  = bus.out_pd;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    sent;
        int    acc_n;
        logic  acc;
        data_t w;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pd    = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", DW'(bus.in_ready), DW'(1));
        chk("rst_out_valid", DW'(bus.out_valid), '0);
        chk("rst_ram_we", DW'(bus.ram_we), '0);
        chk("rst_ram_re", DW'(bus.ram_re), '0);
        chk("rst_occupancy", DW'(occupancy), '0);
        rst = 1'b0;

        // Single word through an empty buffer.
        w = {64{8'hA5}};
        bus.in_pd = w; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk("t1_ram_we", DW'(bus.ram_we), DW'(1));
        chk("t1_ram_wa", DW'(bus.ram_wa), '0);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("t1_ram_re", DW'(bus.ram_re), DW'(1));
        chk("t1_ram_ra", DW'(bus.ram_ra), '0);
        chk("t1_occ_e0", DW'(occupancy), DW'(1));
        chk("t1_vld_e0", DW'(bus.out_valid), '0);
        step();
        chk("t1_vld_e1", DW'(bus.out_valid), '0);
        step();
        chk("t1_vld_e2", DW'(bus.out_valid), DW'(1));
        chk("t1_pd_e2", bus.out_pd, w);
        step();
        chk("t1_occ_e3", DW'(occupancy), '0);

        // 100 words streamed at full rate: last pop lands on edge 102.
        sent = 0; pops_n = 0;
        for (int c = 0; c < 103; c++) begin
            bus.in_valid = (sent < 100);
            bus.in_pd    = data_t'(sent);
            acc          = bus.in_valid && bus.in_ready;
            step();
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        chk("stream_sent", DW'(sent), DW'(100));
        chk("stream_pops", DW'(pops_n), DW'(100));
`ifdef CACC_DBUF_STATS_EN
        chk("stats_ovf_clear", DW'(ovf_seen), '0);
`endif

        // Fill with the consumer stalled: 32 in RAM plus 2 in the skid.
        bus.out_ready = 1'b0; acc_n = 0;
        for (int c = 0; c < 60 && bus.in_ready; c++) begin
            bus.in_valid = 1'b1;
            bus.in_pd    = rand_word();
            step();
            acc_n++;
        end
        chk("fill_accepted", DW'(acc_n), DW'(DEPTH + 2));
        chk("fill_in_ready", DW'(bus.in_ready), '0);
        chk("fill_out_valid", DW'(bus.out_valid), DW'(1));
        repeat (3) step();
        chk("full_in_ready", DW'(bus.in_ready), '0);
        chk("full_occupancy", DW'(occupancy), DW'(DEPTH + 2));
        bus.in_valid = 1'b0;

        // Random traffic, toggling then random backpressure, then drain.
        for (int c = 0; c < 200; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_pd     = rand_word();
            bus.out_ready = (c < 100) ? c[0] : 1'($urandom);
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 80 && occupancy != '0; c++) step();
        chk("drain_occupancy", DW'(occupancy), '0);
        chk("drain_left", DW'(exp_q.size()), '0);

`ifdef CACC_DBUF_STATS_EN
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = 1'b1; bus.in_pd = rand_word();
            step();
        end
        bus.in_valid = 1'b0;
        repeat (4) step();
        chk("stats_hwm", DW'(hwm), DW'(DEPTH + 2));
        chk("stats_ovf", DW'(ovf_seen), DW'(1));
`endif

        // Reset with 10 words held and a read in flight.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 11; c++) begin
            bus.in_valid = 1'b1; bus.in_pd = rand_word();
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step();
        chk("t5_held", DW'(occupancy), DW'(10));
        rst = 1'b1; bus.out_ready = 1'b0;
        step();
        chk("t5_occ", DW'(occupancy), '0);
        chk("t5_out_valid", DW'(bus.out_valid), '0);
        chk("t5_in_ready", DW'(bus.in_ready), DW'(1));
        rst = 1'b0;
        step();
        chk("t5_stale_dout", DW'(bus.out_valid), '0);
        w = rand_word();
        bus.in_valid = 1'b1; bus.in_pd = w; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("t5_vld_e1", DW'(bus.out_valid), '0);
        step();
        chk("t5_vld_e2", DW'(bus.out_valid), DW'(1));
        chk("t5_pd_e2", bus.out_pd, w);
        step();
        chk("t5_occ_end", DW'(occupancy), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
